// File: rtl/vram_scanout_if.sv
// -----------------------------------------------------------------------------
// vram_scanout_if
//
// Read port between the scanout engine and the VRAM framebuffer.
//
//   rd_address  scanout -> VRAM  cell address, registered by the scanout
//   rd_data     VRAM -> scanout  cell contents, valid one clock after the
//                                address changes
//
// Modports:
//   master  the scanout engine (drives the address, consumes the data)
//   slave   the VRAM (consumes the address, drives the data)
// -----------------------------------------------------------------------------
interface vram_scanout_if #(
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 1
) ();

  logic [ADDR_WIDTH-1:0] rd_address;
  logic [DATA_WIDTH-1:0] rd_data;

  modport master (
    output rd_address,
    input  rd_data
  );

  modport slave (
    input  rd_address,
    output rd_data
  );

endinterface : vram_scanout_if

// File: rtl/vram_scanout.sv
// -----------------------------------------------------------------------------
// vram_scanout
//
// Scans the VRAM framebuffer one cell per screen pixel and produces 640x480
// VGA timing with 12-bit colour. A non-zero cell is shown as sand (F/C/4) and a
// zero cell as black. The block also tells the game controller when the beam
// is in vertical blanking, so that framebuffer rewrites can be kept out of the
// visible part of the frame.
//
// Ports:
//   clk_i          system clock
//   reset_i        asynchronous, active-low reset
//   vram           VRAM read port (master side): registered address out,
//                  data in one clock after the address
//   red_o          4-bit red   (registered)
//   green_o        4-bit green (registered)
//   blue_o         4-bit blue  (registered)
//   hsync_o        active-low horizontal sync (registered)
//   vsync_o        active-low vertical sync (registered)
//   vblank_o       high while the displayed line is below the active area
//   frame_start_o  one-clock pulse after the counters wrap back to (0,0)
//
// Timing model: a free-running phase counter divides the clock into pixel
// periods. The clock edge that ends a period (phase == TICKS_PER_PIXEL-1) is
// the pixel edge; it advances the (h,v) beam counters, moves the VRAM address
// to the new pixel and registers the outputs for the pixel that just ended.
// The displayed outputs therefore lag the beam counters by one pixel period.
// -----------------------------------------------------------------------------
module vram_scanout #(
  parameter int ACTIVE_COLUMNS  = 640,
  parameter int ACTIVE_ROWS     = 480,
  parameter int H_FRONT         = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BACK          = 48,
  parameter int V_FRONT         = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BACK          = 33,
  parameter int TICKS_PER_PIXEL = 4,
  parameter int ADDR_WIDTH      = $clog2(ACTIVE_COLUMNS * ACTIVE_ROWS),
  parameter int DATA_WIDTH      = 1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  vram_scanout_if.master        vram,
  output logic [3:0]            red_o,
  output logic [3:0]            green_o,
  output logic [3:0]            blue_o,
  output logic                  hsync_o,
  output logic                  vsync_o,
  output logic                  vblank_o,
  output logic                  frame_start_o
);

  // ---------------------------------------------------------------------------
  // Derived geometry
  // ---------------------------------------------------------------------------
  localparam int H_TOTAL = ACTIVE_COLUMNS + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = ACTIVE_ROWS + V_FRONT + V_SYNC + V_BACK;

  // One extra value of headroom so that a sync window ending exactly at the
  // line/frame total still fits when the total is a power of two.
  localparam int H_WIDTH     = $clog2(H_TOTAL + 1);
  localparam int V_WIDTH     = $clog2(V_TOTAL + 1);
  localparam int PHASE_WIDTH = $clog2(TICKS_PER_PIXEL);

  localparam logic [PHASE_WIDTH-1:0] PHASE_LAST = PHASE_WIDTH'(TICKS_PER_PIXEL - 1);

  localparam logic [H_WIDTH-1:0] H_LAST       = H_WIDTH'(H_TOTAL - 1);
  localparam logic [H_WIDTH-1:0] H_ACTIVE_END = H_WIDTH'(ACTIVE_COLUMNS);
  localparam logic [H_WIDTH-1:0] H_SYNC_START = H_WIDTH'(ACTIVE_COLUMNS + H_FRONT);
  localparam logic [H_WIDTH-1:0] H_SYNC_END   = H_WIDTH'(ACTIVE_COLUMNS + H_FRONT + H_SYNC);

  localparam logic [V_WIDTH-1:0] V_LAST       = V_WIDTH'(V_TOTAL - 1);
  localparam logic [V_WIDTH-1:0] V_ACTIVE_END = V_WIDTH'(ACTIVE_ROWS);
  localparam logic [V_WIDTH-1:0] V_SYNC_START = V_WIDTH'(ACTIVE_ROWS + V_FRONT);
  localparam logic [V_WIDTH-1:0] V_SYNC_END   = V_WIDTH'(ACTIVE_ROWS + V_FRONT + V_SYNC);

  typedef struct packed {
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
  } colour_t;

  localparam colour_t SAND  = '{red: 4'hF, green: 4'hC, blue: 4'h4};
  localparam colour_t BLACK = '{red: 4'h0, green: 4'h0, blue: 4'h0};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PHASE_WIDTH-1:0] phase_q;
  logic [H_WIDTH-1:0]     h_q;
  logic [V_WIDTH-1:0]     v_q;
  logic [ADDR_WIDTH-1:0]  addr_q;

  // ---------------------------------------------------------------------------
  // Next-state and decode
  // ---------------------------------------------------------------------------
  logic               pixel_edge;
  logic               h_wrap;
  logic               v_wrap;
  logic               frame_wrap;
  logic [H_WIDTH-1:0] h_next;
  logic [V_WIDTH-1:0] v_next;
  logic               active_now;
  logic               active_next;
  logic               hsync_now;
  logic               vsync_now;
  logic               vblank_now;
  colour_t            pixel_colour;

  // NOTE: every signal gets a value on every path through always_comb; a path
  // that leaves one unassigned would make synthesis infer a latch.
  always_comb begin
    pixel_edge = (phase_q == PHASE_LAST);
    h_wrap     = (h_q == H_LAST);
    v_wrap     = (v_q == V_LAST);
    frame_wrap = pixel_edge && h_wrap && v_wrap;

    h_next = h_q + H_WIDTH'(1);
    v_next = v_q;
    if (h_wrap) begin
      h_next = '0;
      v_next = v_wrap ? '0 : v_q + V_WIDTH'(1);
    end

    active_now  = (h_q < H_ACTIVE_END) && (v_q < V_ACTIVE_END);
    active_next = (h_next < H_ACTIVE_END) && (v_next < V_ACTIVE_END);

    hsync_now  = !((h_q >= H_SYNC_START) && (h_q < H_SYNC_END));
    vsync_now  = !((v_q >= V_SYNC_START) && (v_q < V_SYNC_END));
    vblank_now = (v_q >= V_ACTIVE_END);

    // Data for the current pixel has been on the bus since one clock after the
    // address moved, so it is settled by the pixel edge that ends the period.
    pixel_colour = BLACK;
    if (active_now && (|vram.rd_data)) begin
      pixel_colour = SAND;
    end
  end

  // ---------------------------------------------------------------------------
  // Beam counters
  // ---------------------------------------------------------------------------
  // NOTE: registers are written with non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      phase_q <= '0;
      h_q     <= '0;
      v_q     <= '0;
    end else begin
      phase_q <= pixel_edge ? '0 : phase_q + PHASE_WIDTH'(1);
      if (pixel_edge) begin
        h_q <= h_next;
        v_q <= v_next;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // VRAM address
  //
  // Active cells are visited in raster order, so v*ACTIVE_COLUMNS+h is just a
  // running count of active pixels: step by one when the beam enters an active
  // pixel, hold through blanking, restart at the frame wrap. The count stops at
  // ACTIVE_COLUMNS*ACTIVE_ROWS-1 on the last visible pixel and holds there
  // through vertical blanking.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      addr_q <= '0;
    end else if (frame_wrap) begin
      addr_q <= '0;
    end else if (pixel_edge && active_next) begin
      addr_q <= addr_q + ADDR_WIDTH'(1);
    end
  end

  assign vram.rd_address = addr_q;

  // ---------------------------------------------------------------------------
  // Video outputs: registered from the pixel that the edge is closing.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      {red_o, green_o, blue_o} <= BLACK;
      hsync_o                  <= 1'b1;
      vsync_o                  <= 1'b1;
      vblank_o                 <= 1'b0;
    end else if (pixel_edge) begin
      {red_o, green_o, blue_o} <= pixel_colour;
      hsync_o                  <= hsync_now;
      vsync_o                  <= vsync_now;
      vblank_o                 <= vblank_now;
    end
  end

  // Pulse lasts exactly the clock after the frame-wrap edge. Reset clears it
  // and leaves the beam at (0,0) without a wrap, so a restart never pulses.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      frame_start_o <= 1'b0;
    end else begin
      frame_start_o <= frame_wrap;
    end
  end

endmodule : vram_scanout
